// File: rtl/mem_port_scheduler.sv
// mem_port_scheduler: shares one cacheline adaptor port between the I-cache
// and D-cache. Data requests win arbitration unless the starvation counter
// shows the waiting fetch has lost STARVE_LIMIT times in a row. The winning
// request is captured at grant and drives the adaptor until mem_resp, then a
// single RELEASE bubble lets the requester drop its request before the next
// arbitration.
//
// Handshake: a requester holds its read/write request and address stable until
// its resp pulse; resp is a single-cycle combinational qualifier of the shared
// rdata bus. Toward the adaptor, mem_read/mem_write stay high from the cycle
// after grant through the mem_resp cycle inclusive.
module mem_port_scheduler #(
    parameter int LINE_W       = 256,
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              inst_read,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [LINE_W-1:0] inst_rdata,
    output logic              inst_resp,
    input  logic              data_read,
    input  logic              data_write,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [LINE_W-1:0] data_wdata,
    output logic [LINE_W-1:0] data_rdata,
    output logic              data_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic              busy
);

    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << OFF_W;
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_INST    = 2'd1,
        ST_DATA    = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              data_req;

    assign data_req = data_read | data_write;

    // Arbitration, grant capture and ownership tracking.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        case (state_q)
            ST_IDLE: begin
                if (inst_read && (!data_req || cnt_q == CNT_MAX)) begin
                    state_d = ST_INST;
                    cnt_d   = '0;
                    addr_d  = inst_addr & ADDR_MASK;
                    wdata_d = '0;
                    rd_d    = 1'b1;
                    wr_d    = 1'b0;
                end else if (data_req) begin
                    state_d = ST_DATA;
                    if (inst_read) begin
                        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = '0;
                    end
                    addr_d  = data_addr & ADDR_MASK;
                    // Read+write together is illegal; the write takes precedence.
                    wdata_d = data_write ? data_wdata : '0;
                    rd_d    = ~data_write;
                    wr_d    = data_write;
                end
            end
            ST_INST, ST_DATA: begin
                if (mem_resp) begin
                    state_d = ST_RELEASE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    // State, counter and captured-request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    assign mem_read   = rd_q;
    assign mem_write  = wr_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign busy       = (state_q != ST_IDLE);
    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;
    assign inst_resp  = (state_q == ST_INST) && mem_resp;
    assign data_resp  = (state_q == ST_DATA) && mem_resp;

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Directed bench for mem_port_scheduler with hand-computed expectations.
module tb_mem_port_scheduler;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  logic              clk;
  logic              reset_n;
  logic              inst_read;
  logic [ADDR_W-1:0] inst_addr;
  logic [LINE_W-1:0] inst_rdata;
  logic              inst_resp;
  logic              data_read;
  logic              data_write;
  logic [ADDR_W-1:0] data_addr;
  logic [LINE_W-1:0] data_wdata;
  logic [LINE_W-1:0] data_rdata;
  logic              data_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;
  logic              busy;

  int checks = 0;
  int errors = 0;

  mem_port_scheduler #(
    .LINE_W(LINE_W),
    .ADDR_W(ADDR_W),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .inst_read(inst_read),
    .inst_addr(inst_addr),
    .inst_rdata(inst_rdata),
    .inst_resp(inst_resp),
    .data_read(data_read),
    .data_write(data_write),
    .data_addr(data_addr),
    .data_wdata(data_wdata),
    .data_rdata(data_rdata),
    .data_resp(data_resp),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_resp(mem_resp),
    .busy(busy)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a grant edge. Checks the strobes for wait_n cycles,
  // returns mem_resp, checks the owner/non-owner resp, then leaves the DUT
  // in RELEASE with the served requester's request dropped.
  task automatic run_grant(input string tag, input bit is_inst, input bit is_write,
                           input logic [ADDR_W-1:0] exp_addr,
                           input logic [LINE_W-1:0] exp_wdata, input int wait_n);
    logic [LINE_W-1:0] rdat;
    for (int i = 0; i < wait_n; i++) begin
      check({tag, " mem_read"}, LINE_W'(mem_read), LINE_W'(!is_write));
      check({tag, " mem_write"}, LINE_W'(mem_write), LINE_W'(is_write));
      check({tag, " mem_addr"}, LINE_W'(mem_addr), LINE_W'(exp_addr));
      check({tag, " mem_wdata"}, mem_wdata, exp_wdata);
      check({tag, " busy"}, LINE_W'(busy), 1);
      check({tag, " resp_idle"}, LINE_W'({inst_resp, data_resp}), 0);
      tick();
    end
    rdat = {8{$urandom()}};
    mem_rdata = rdat;
    mem_resp  = 1'b1;
    #1;
    check({tag, " strobe_at_resp"}, LINE_W'({mem_read, mem_write}), LINE_W'({!is_write, is_write}));
    check({tag, " inst_resp"}, LINE_W'(inst_resp), LINE_W'(is_inst));
    check({tag, " data_resp"}, LINE_W'(data_resp), LINE_W'(!is_inst));
    check({tag, " rdata"}, is_inst ? inst_rdata : data_rdata, rdat);
    tick();
    mem_resp = 1'b0;
    if (is_inst) inst_read = 1'b0;
    else begin
      data_read  = 1'b0;
      data_write = 1'b0;
    end
    #1;
    check({tag, " release_strobes"}, LINE_W'({mem_read, mem_write}), 0);
    check({tag, " release_busy"}, LINE_W'(busy), 1);
  endtask

  logic [LINE_W-1:0] pat_a;
  logic [LINE_W-1:0] pat_b;
  bit                grant_inst;

  initial begin
    pat_a      = {8{32'hA5A5_0001}};
    pat_b      = {8{32'h5A5A_F00D}};
    reset_n    = 1'b0;
    inst_read  = 1'b1;
    inst_addr  = 32'h0000_ABCD;
    data_read  = 1'b0;
    data_write = 1'b0;
    data_addr  = '0;
    data_wdata = '0;
    mem_rdata  = '0;
    mem_resp   = 1'b0;

    // Reset with a fetch already pending.
    tick();
    tick();
    check("rst mem_read", LINE_W'(mem_read), 0);
    check("rst mem_write", LINE_W'(mem_write), 0);
    check("rst busy", LINE_W'(busy), 0);
    check("rst resp", LINE_W'({inst_resp, data_resp}), 0);
    check("rst mem_addr", LINE_W'(mem_addr), 0);
    check("rst mem_wdata", mem_wdata, 0);
    reset_n = 1'b1;
    tick();
    check("post_rst mem_read", LINE_W'(mem_read), 1);
    check("post_rst mem_addr", LINE_W'(mem_addr), LINE_W'(32'h0000_ABC0));
    run_grant("fetch0", 1'b1, 1'b0, 32'h0000_ABC0, '0, 2);
    tick();
    check("fetch0 idle", LINE_W'(busy), 0);

    // Single writeback, resp on the 10th strobe cycle.
    data_write = 1'b1;
    data_addr  = 32'h0000_1234;
    data_wdata = pat_a;
    tick();
    run_grant("wb", 1'b0, 1'b1, 32'h0000_1220, pat_a, 9);
    tick();
    check("wb idle", LINE_W'(busy), 0);

    // Simultaneous requests with counter 0: data first, bubble, then fetch.
    inst_read = 1'b1;
    inst_addr = 32'h0001_0040;
    data_read = 1'b1;
    data_addr = 32'h0002_007F;
    tick();
    run_grant("both_d", 1'b0, 1'b0, 32'h0002_0060, '0, 1);
    tick();
    check("both bubble_idle", LINE_W'(busy), 0);
    check("both bubble_strobe", LINE_W'(mem_read), 0);
    tick();
    run_grant("both_i", 1'b1, 1'b0, 32'h0001_0040, '0, 1);
    tick();

    // Starvation: fetch held, data reissued -> D,D,D,D,I,D,D,D,D,I.
    inst_read = 1'b1;
    data_read = 1'b1;
    for (int g = 0; g < 10; g++) begin
      grant_inst = (g == 4) || (g == 9);
      tick();
      run_grant(grant_inst ? "starve_i" : "starve_d", grant_inst, 1'b0,
                grant_inst ? 32'h0001_0040 : 32'h0002_0060, '0, 1);
      inst_read = 1'b1;
      data_read = 1'b1;
      tick();
    end
    inst_read = 1'b0;
    data_read = 1'b0;
    tick();
    check("starve done idle", LINE_W'(busy), 0);

    // Stray mem_resp in IDLE is ignored.
    mem_resp = 1'b1;
    #1;
    check("stray resp", LINE_W'({inst_resp, data_resp}), 0);
    tick();
    check("stray busy", LINE_W'(busy), 0);
    check("stray strobes", LINE_W'({mem_read, mem_write}), 0);
    mem_resp = 1'b0;

    // Reset mid-transaction abandons it.
    data_read = 1'b1;
    data_addr = 32'h0000_3300;
    tick();
    check("abort granted", LINE_W'(mem_read), 1);
    reset_n = 1'b0;
    tick();
    check("abort busy", LINE_W'(busy), 0);
    check("abort strobes", LINE_W'({mem_read, mem_write}), 0);
    check("abort addr", LINE_W'(mem_addr), 0);
    mem_resp = 1'b1;
    #1;
    check("abort resp", LINE_W'({inst_resp, data_resp}), 0);
    mem_resp  = 1'b0;
    data_read = 1'b0;
    reset_n   = 1'b1;
    tick();

    // Illegal read+write is treated as a write.
    data_read  = 1'b1;
    data_write = 1'b1;
    data_addr  = 32'h4444_5678;
    data_wdata = pat_b;
    tick();
    run_grant("rw", 1'b0, 1'b1, 32'h4444_5660, pat_b, 3);
    tick();
    check("rw idle", LINE_W'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
